inst_fetch_bridge: RTL

INST_FETCH_BRIDGE -- requirements
Module: inst_fetch_bridge

---
 rtl/inst_fetch_bridge_if.sv | 43 ++++
 rtl/inst_fetch_bridge.sv | 135 +++++++++++++
 2 files changed

// File: rtl/inst_fetch_bridge_if.sv
// Fetch-bridge bus: pc_select request, instruction-SRAM handshake and fetch packet toward if_to_id.
// fetch_err exists only when FETCH_TIMEOUT_EN is defined.
interface inst_fetch_bridge_if #(
   parameter int unsigned ADDR_W = 32
);
   localparam int unsigned INST_W = 128;

   logic [ADDR_W-1:0] pc_in;
   logic              pc_valid;
   logic              stall;
   logic              flash;
   logic              sram_req;
   logic [ADDR_W-1:0] sram_addr;
   logic              sram_gnt;
   logic              sram_rvalid;
   logic [INST_W-1:0] sram_rdata;
   logic              pkt_valid;
   logic [ADDR_W-1:0] pkt_pc;
   logic [INST_W-1:0] pkt_inst;
   logic [3:0]        pkt_mask;
   logic              busy;
`ifdef FETCH_TIMEOUT_EN
   logic              fetch_err;
`endif

   // Bridge side
   modport master (
      input  pc_in, pc_valid, stall, flash, sram_gnt, sram_rvalid, sram_rdata,
      output sram_req, sram_addr, pkt_valid, pkt_pc, pkt_inst, pkt_mask, busy
`ifdef FETCH_TIMEOUT_EN
      , output fetch_err
`endif
   );

   // Surrounding pipeline and memory side
   modport slave (
      output pc_in, pc_valid, stall, flash, sram_gnt, sram_rvalid, sram_rdata,
      input  sram_req, sram_addr, pkt_valid, pkt_pc, pkt_inst, pkt_mask, busy
`ifdef FETCH_TIMEOUT_EN
      , input fetch_err
`endif
   );
endinterface

// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: one outstanding 128-bit SRAM fetch per pc, with branch squash (flash).
// Optional watchdog on the SRAM response enabled by defining FETCH_TIMEOUT_EN.
module inst_fetch_bridge #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                rst,
   inst_fetch_bridge_if.master bus
);
   localparam int unsigned INST_W = 128;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DROP
   } state_e;

   generate
      if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255 || ADDR_W < 4) begin : g_bad_cfg
         $error("inst_fetch_bridge: TIMEOUT_CYC must be 1..255 and ADDR_W >= 4");
      end
   endgenerate

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic                pkt_valid_q;
   logic [ADDR_W-1:0]   pkt_pc_q;
   logic [INST_W-1:0]   pkt_inst_q;
   logic [3:0]          pkt_mask_q;
   logic                load_pkt;
   logic                timeout_hit;

   // Next-state logic; flash always takes priority over forward progress
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      load_pkt = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.pc_valid && !bus.flash) begin
               pc_d    = bus.pc_in;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.flash)         state_d = bus.sram_gnt ? S_DROP : S_IDLE;
            else if (bus.sram_gnt) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.sram_rvalid) begin
               state_d  = bus.flash ? S_IDLE : S_HOLD;
               load_pkt = !bus.flash;
            end else if (bus.flash) begin
               state_d = S_DROP;
            end else if (timeout_hit) begin
               state_d = S_IDLE;
            end
         end
         S_HOLD: begin
            if (bus.flash || !bus.stall) state_d = S_IDLE;
         end
         S_DROP: begin
            if (bus.sram_rvalid || timeout_hit) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pc_q        <= '0;
         pkt_valid_q <= 1'b0;
         pkt_pc_q    <= '0;
         pkt_inst_q  <= '0;
         pkt_mask_q  <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pkt_valid_q <= (state_d == S_HOLD);
         if (load_pkt) begin
            pkt_pc_q   <= pc_q;
            pkt_inst_q <= bus.sram_rdata;
            pkt_mask_q <= 4'(4'b1111 << pc_q[3:2]);
         end
      end
   end

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned CNT_W = 8;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fetch_err_q;
   logic             waiting;

   assign waiting     = (state_q == S_WAIT) || (state_q == S_DROP);
   assign timeout_hit = waiting && !bus.sram_rvalid && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   // Counter restarts on every entry into WAIT or DROP, including WAIT->DROP
   always_comb begin
      cnt_d = cnt_q;
      if ((state_d == S_WAIT || state_d == S_DROP) && state_d != state_q) begin
         cnt_d = '0;
      end else if (waiting && !bus.sram_rvalid) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         fetch_err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (timeout_hit && state_d == S_IDLE) fetch_err_q <= 1'b1;
      end
   end

   assign bus.fetch_err = fetch_err_q;
`else
   assign timeout_hit = 1'b0;
`endif

   // sram_req drops in the same cycle a flash arrives, so it is decoded from the live flash input
   assign bus.sram_req  = (state_q == S_REQ) && !bus.flash;
   assign bus.sram_addr = {pc_q[ADDR_W-1:4], 4'b0000};
   assign bus.pkt_valid = pkt_valid_q;
   assign bus.pkt_pc    = pkt_pc_q;
   assign bus.pkt_inst  = pkt_inst_q;
   assign bus.pkt_mask  = pkt_mask_q;
   assign bus.busy      = (state_q != S_IDLE);
endmodule
